// File: rtl/ua_transmitter.sv
// ua_transmitter
// ----------------------------------------------------------------------------
// RS232/16550-style serial transmitter. A parallel word accepted over a
// ready/valid handshake is sent on SOut as one frame: a start bit (0), the
// data LSB first, an optional parity bit, then StopBits stop bits (1). The
// line idles high. Parameters match the team's UART receiver, so a pair with
// identical settings interoperates.
//
// Handshake: a word transfers on a rising edge where DataInValid and
// DataInReady are both high. DataInReady is high only in IDLE with Reset low.
// DataInValid without DataInReady is ignored and nothing is queued. DataIn is
// captured on the accepting edge, and later changes do not affect the frame.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous, active-high reset
//   DataIn       in   [Width-1:0] word to transmit
//   DataInValid  in   producer offers a word
//   DataInReady  out  transmitter accepts a word this cycle
//   SOut         out  serial line, driven straight from a flop
//   StateDbg     out  debug view of the FSM state (0 IDLE, 1 SEND)
// ----------------------------------------------------------------------------
module ua_transmitter #(
    parameter int ClockFreq = 27000000,
    parameter int Baud      = 115200,
    parameter int Width     = 8,
    parameter int Parity    = 0,  // 0 none, 1 even, 2 odd, 3 mark, 4 space
    parameter int StopBits  = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] DataIn,
    input  logic             DataInValid,
    output logic             DataInReady,
    output logic             SOut,
    output logic             StateDbg
);

    localparam int Divisor   = ClockFreq / Baud;
    localparam int HasParity = (Parity != 0) ? 1 : 0;
    localparam int BitCount  = 1 + Width + HasParity + StopBits;
    localparam int DivW      = (Divisor > 1) ? $clog2(Divisor) : 1;
    localparam int BitW      = $clog2(BitCount + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [BitCount-1:0] shift_q, shift_d;

    logic                parity_bit;
    logic [BitCount-1:0] frame_load;
    logic                div_wrap;

    // Parity is computed over the word as it is presented on the accepting edge.
    always_comb begin
        case (Parity)
            1:       parity_bit = ^DataIn;
            2:       parity_bit = ~^DataIn;
            3:       parity_bit = 1'b1;
            default: parity_bit = 1'b0;
        endcase
    end

    // Frame image, start bit in bit 0. The stop bits come from the all-ones
    // default, and the parity slot is present only when parity is enabled.
    always_comb begin
        frame_load           = '1;
        frame_load[0]        = 1'b0;
        frame_load[Width:1]  = DataIn;
        if (Parity != 0) begin
            frame_load[Width+1] = parity_bit;
        end
    end

    assign div_wrap = (div_q == DivW'(Divisor - 1));

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (DataInValid && DataInReady) begin
                    shift_d = frame_load;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (div_wrap) begin
                    div_d   = '0;
                    // Shifting in ones means the register is all ones again
                    // once the last stop bit is gone, which keeps the idle
                    // line high without a separate output mux.
                    shift_d = {1'b1, shift_q[BitCount-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BitW'(BitCount - 1)) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        DataInReady = (state_q == ST_IDLE) && !Reset;
        StateDbg    = (state_q == ST_SEND);
    end

    assign SOut = shift_q[0];

endmodule
